// File: rtl/sr_ff_bank.sv
// Bank of N clocked SR storage bits with selectable S=R=1 policy, edge pulses
// and sticky collision flags. Optional cycle counter: SR_FF_BANK_CONFLICT_CNT_EN.
module sr_ff_bank #(
  parameter int unsigned  N     = 8,
  parameter int unsigned  MODE  = 0,
  parameter logic [N-1:0] INIT  = {N{1'b0}},
  parameter int unsigned  CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] s,
  input  logic [N-1:0] r,
  input  logic         clr_conflict,
  output logic [N-1:0] q,
  output logic [N-1:0] qn,
  output logic [N-1:0] q_rise,
  output logic [N-1:0] q_fall,
  output logic [N-1:0] conflict,
  output logic         any_conflict
`ifdef SR_FF_BANK_CONFLICT_CNT_EN
  ,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  if (MODE > 3) begin : g_bad_mode
    $error("sr_ff_bank: MODE must be 0..3");
  end
  if (N < 1 || N > 64) begin : g_bad_n
    $error("sr_ff_bank: N must be 1..64");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("sr_ff_bank: CNT_W must be at least 1");
  end

  logic [N-1:0] q_q, q_d;
  logic [N-1:0] rise_q, rise_d;
  logic [N-1:0] fall_q, fall_d;
  logic [N-1:0] conf_q, conf_d;
  logic [N-1:0] both;
  logic [N-1:0] both_val;
  logic [N-1:0] coll;

  // Value a channel takes when both set and reset are requested.
  if (MODE == 1) begin : g_set_dom
    assign both_val = {N{1'b1}};
  end else if (MODE == 2) begin : g_rst_dom
    assign both_val = {N{1'b0}};
  end else if (MODE == 3) begin : g_toggle
    assign both_val = ~q_q;
  end else begin : g_hold
    assign both_val = q_q;
  end

  always_comb begin
    both = s & r;
    coll = en ? both : {N{1'b0}};
    q_d  = q_q;
    if (en) begin
      q_d = (s & ~r) | (q_q & ~(s | r)) | (both & both_val);
    end
    rise_d = q_d & ~q_q;
    fall_d = ~q_d & q_q;
    // A collision in the clearing cycle survives the clear.
    conf_d = (clr_conflict ? {N{1'b0}} : conf_q) | coll;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= INIT;
      rise_q <= {N{1'b0}};
      fall_q <= {N{1'b0}};
      conf_q <= {N{1'b0}};
    end else begin
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      conf_q <= conf_d;
    end
  end

  assign q            = q_q;
  assign qn           = ~q_q;
  assign q_rise       = rise_q;
  assign q_fall       = fall_q;
  assign conflict     = conf_q;
  assign any_conflict = |conf_q;

`ifdef SR_FF_BANK_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             any_coll;

  // Counts collision cycles, not channels; saturates at all-ones.
  always_comb begin
    any_coll = |coll;
    cnt_d    = cnt_q;
    if (clr_conflict) begin
      cnt_d = any_coll ? CNT_W'(1) : '0;
    end else if (any_coll && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed bench for sr_ff_bank: one instance per MODE sharing all inputs,
// table-driven vectors plus hand sequences for reset, toggle and counter.
module tb_sr_ff_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] s, r;
  logic       clr;

  logic [7:0] q_w    [4];
  logic [7:0] qn_w   [4];
  logic [7:0] rise_w [4];
  logic [7:0] fall_w [4];
  logic [7:0] conf_w [4];
  logic       any_w  [4];
`ifdef SR_FF_BANK_CONFLICT_CNT_EN
  logic [1:0] cnt_w  [4];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    sr_ff_bank #(.N(8), .MODE(m), .INIT(8'hA5), .CNT_W(2)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .s            (s),
      .r            (r),
      .clr_conflict (clr),
      .q            (q_w[m]),
      .qn           (qn_w[m]),
      .q_rise       (rise_w[m]),
      .q_fall       (fall_w[m]),
      .conflict     (conf_w[m]),
      .any_conflict (any_w[m])
`ifdef SR_FF_BANK_CONFLICT_CNT_EN
      ,
      .conflict_cnt (cnt_w[m])
`endif
    );
  end

  typedef struct {
    logic            en;
    logic [7:0]      s;
    logic [7:0]      r;
    logic            clr;
    logic [3:0][7:0] q;     // per MODE, index = MODE
    logic [3:0][7:0] rise;
    logic [3:0][7:0] fall;
    logic [7:0]      conf;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [3:0][7:0] p4(input logic [7:0] m0, m1, m2, m3);
    return {m3, m2, m1, m0};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic e, input logic [7:0] sv, input logic [7:0] rv, input logic c);
    en  = e;
    s   = sv;
    r   = rv;
    clr = c;
  endtask

  initial begin
    //               en    s      r      clr   q (m0..m3)                       rise                               fall                               conf
    vecs[0]  = '{1'b1, 8'h00, 8'hFF, 1'b0, p4(8'h00,8'h00,8'h00,8'h00), p4(8'h00,8'h00,8'h00,8'h00), p4(8'hA5,8'hA5,8'hA5,8'hA5), 8'h00};
    vecs[1]  = '{1'b1, 8'h0F, 8'h00, 1'b0, p4(8'h0F,8'h0F,8'h0F,8'h0F), p4(8'h0F,8'h0F,8'h0F,8'h0F), p4(8'h00,8'h00,8'h00,8'h00), 8'h00};
    vecs[2]  = '{1'b1, 8'h00, 8'h03, 1'b0, p4(8'h0C,8'h0C,8'h0C,8'h0C), p4(8'h00,8'h00,8'h00,8'h00), p4(8'h03,8'h03,8'h03,8'h03), 8'h00};
    vecs[3]  = '{1'b1, 8'h00, 8'h00, 1'b0, p4(8'h0C,8'h0C,8'h0C,8'h0C), p4(8'h00,8'h00,8'h00,8'h00), p4(8'h00,8'h00,8'h00,8'h00), 8'h00};
    vecs[4]  = '{1'b0, 8'hFF, 8'hFF, 1'b0, p4(8'h0C,8'h0C,8'h0C,8'h0C), p4(8'h00,8'h00,8'h00,8'h00), p4(8'h00,8'h00,8'h00,8'h00), 8'h00};
    vecs[5]  = '{1'b1, 8'h00, 8'hFF, 1'b0, p4(8'h00,8'h00,8'h00,8'h00), p4(8'h00,8'h00,8'h00,8'h00), p4(8'h0C,8'h0C,8'h0C,8'h0C), 8'h00};
    vecs[6]  = '{1'b1, 8'h01, 8'h00, 1'b0, p4(8'h01,8'h01,8'h01,8'h01), p4(8'h01,8'h01,8'h01,8'h01), p4(8'h00,8'h00,8'h00,8'h00), 8'h00};
    vecs[7]  = '{1'b1, 8'h01, 8'h01, 1'b0, p4(8'h01,8'h01,8'h00,8'h00), p4(8'h00,8'h00,8'h00,8'h00), p4(8'h00,8'h00,8'h01,8'h01), 8'h01};
    vecs[8]  = '{1'b1, 8'h00, 8'h00, 1'b1, p4(8'h01,8'h01,8'h00,8'h00), p4(8'h00,8'h00,8'h00,8'h00), p4(8'h00,8'h00,8'h00,8'h00), 8'h00};
    vecs[9]  = '{1'b1, 8'h20, 8'h20, 1'b1, p4(8'h01,8'h21,8'h00,8'h20), p4(8'h00,8'h20,8'h00,8'h20), p4(8'h00,8'h00,8'h00,8'h00), 8'h20};
    vecs[10] = '{1'b1, 8'h00, 8'hFF, 1'b0, p4(8'h00,8'h00,8'h00,8'h00), p4(8'h00,8'h00,8'h00,8'h00), p4(8'h01,8'h21,8'h00,8'h20), 8'h20};
    vecs[11] = '{1'b1, 8'h00, 8'h00, 1'b1, p4(8'h00,8'h00,8'h00,8'h00), p4(8'h00,8'h00,8'h00,8'h00), p4(8'h00,8'h00,8'h00,8'h00), 8'h00};

    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Move away from INIT, then reset mid-cycle and look before the next edge.
    drive(1'b1, 8'h0F, 8'hF0, 1'b0);
    step();
    chk("pre_reset_q_m0", q_w[0], 8'h0F);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    #2 rst = 1'b1;
    #1;
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("async_rst_q_m%0d", m), q_w[m], 8'hA5);
      chk($sformatf("async_rst_qn_m%0d", m), qn_w[m], 8'h5A);
      chk($sformatf("async_rst_rise_m%0d", m), rise_w[m], 8'h00);
      chk($sformatf("async_rst_fall_m%0d", m), fall_w[m], 8'h00);
      chk($sformatf("async_rst_conf_m%0d", m), conf_w[m], 8'h00);
      chk($sformatf("async_rst_any_m%0d", m), {7'd0, any_w[m]}, 8'h00);
`ifdef SR_FF_BANK_CONFLICT_CNT_EN
      chk($sformatf("async_rst_cnt_m%0d", m), {6'd0, cnt_w[m]}, 8'h00);
`endif
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 8'h00, 8'h00, 1'b0);
    step();
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("release_q_m%0d", m), q_w[m], 8'hA5);
      chk($sformatf("release_rise_m%0d", m), rise_w[m], 8'h00);
      chk($sformatf("release_fall_m%0d", m), fall_w[m], 8'h00);
    end

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].en, vecs[i].s, vecs[i].r, vecs[i].clr);
      step();
      for (int m = 0; m < 4; m++) begin
        chk($sformatf("v%0d_q_m%0d", i, m), q_w[m], vecs[i].q[m]);
        chk($sformatf("v%0d_qn_m%0d", i, m), qn_w[m], ~vecs[i].q[m]);
        chk($sformatf("v%0d_rise_m%0d", i, m), rise_w[m], vecs[i].rise[m]);
        chk($sformatf("v%0d_fall_m%0d", i, m), fall_w[m], vecs[i].fall[m]);
        chk($sformatf("v%0d_conf_m%0d", i, m), conf_w[m], vecs[i].conf);
        chk($sformatf("v%0d_any_m%0d", i, m), {7'd0, any_w[m]}, {7'd0, |vecs[i].conf});
      end
    end

    // Toggle run on channel 2 with S=R held for four cycles (all q start at 0).
    begin
      logic [7:0] t_q    [4];
      logic [7:0] t_rise [4];
      logic [7:0] t_fall [4];
      t_q    = '{8'h04, 8'h00, 8'h04, 8'h00};
      t_rise = '{8'h04, 8'h00, 8'h04, 8'h00};
      t_fall = '{8'h00, 8'h04, 8'h00, 8'h04};
      drive(1'b1, 8'h04, 8'h04, 1'b0);
      for (int c = 0; c < 4; c++) begin
        step();
        chk($sformatf("tog%0d_q_m3", c), q_w[3], t_q[c]);
        chk($sformatf("tog%0d_rise_m3", c), rise_w[3], t_rise[c]);
        chk($sformatf("tog%0d_fall_m3", c), fall_w[3], t_fall[c]);
        chk($sformatf("tog%0d_q_m1", c), q_w[1], 8'h04);
        chk($sformatf("tog%0d_rise_m1", c), rise_w[1], (c == 0) ? 8'h04 : 8'h00);
        chk($sformatf("tog%0d_q_m0", c), q_w[0], 8'h00);
        chk($sformatf("tog%0d_q_m2", c), q_w[2], 8'h00);
        chk($sformatf("tog%0d_conf_m3", c), conf_w[3], 8'h04);
      end
    end

`ifdef SR_FF_BANK_CONFLICT_CNT_EN
    begin
      logic [1:0] c_exp [5];
      c_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      drive(1'b1, 8'h00, 8'h00, 1'b1);
      step();
      chk("cnt_cleared", {6'd0, cnt_w[0]}, 8'h00);
      chk("conf_cleared", conf_w[0], 8'h00);
      drive(1'b1, 8'h01, 8'h01, 1'b0);
      for (int c = 0; c < 5; c++) begin
        step();
        chk($sformatf("cnt_sat%0d", c), {6'd0, cnt_w[0]}, {6'd0, c_exp[c]});
      end
      drive(1'b1, 8'h00, 8'h00, 1'b1);
      step();
      chk("cnt_clr", {6'd0, cnt_w[0]}, 8'h00);
      drive(1'b1, 8'h03, 8'h03, 1'b1);
      step();
      chk("cnt_clr_coll", {6'd0, cnt_w[0]}, 8'h01);
      chk("conf_clr_coll", conf_w[0], 8'h03);
      drive(1'b0, 8'hFF, 8'hFF, 1'b0);
      step();
      chk("cnt_en_off", {6'd0, cnt_w[0]}, 8'h01);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
